// File: rtl/btn_event_fsm_pkg.sv
// Shared types and defaults for the button event FSM and its prescaler.
package btn_event_fsm_pkg;

    // Prescaler width shared with the switch debouncer (~10.5 ms tick @ 50 MHz).
    localparam int unsigned DefaultTickBits = 19;

    // FSM state encoding; 2'b11 is unused and recovers to StIdle.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPress = 2'b01,
        StLong  = 2'b10
    } state_e;

    // Registered output bundle.
    typedef struct packed {
        logic press;
        logic rel;
        logic short_click;
        logic long_press;
        logic rpt;
        logic held;
    } btn_out_t;

endpackage

// File: rtl/btn_event_fsm_tick_gen.sv
// Free-running prescaler with synchronous clear; tick while the count is all ones.
module btn_event_fsm_tick_gen
    import btn_event_fsm_pkg::*;
#(
    parameter int unsigned TICK_BITS = DefaultTickBits
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    logic [TICK_BITS-1:0] cnt_q, cnt_d;

    // Clear wins over count; natural wrap from all ones back to zero.
    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q + TICK_BITS'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = &cnt_q;

endmodule

// File: rtl/btn_event_fsm.sv
// Turns the debounced button level into press/release/click/long/repeat events.
module btn_event_fsm
    import btn_event_fsm_pkg::*;
#(
    parameter int unsigned TICK_BITS    = DefaultTickBits,
    parameter int unsigned LONG_TICKS   = 96,
    parameter int unsigned REPEAT_TICKS = 19,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic db_i,
    output logic press_o,
    output logic release_o,
    output logic short_click_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);
    localparam bit               RepeatOn   = (REPEAT_TICKS != 0);

    logic             db_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    btn_out_t         out_q, out_d;
    logic             rise, fall, tick, presc_clr;

    assign rise = db_i & ~db_q;
    assign fall = ~db_i & db_q;

    // Prescaler idles at zero and restarts on every rise so ticks align to the press.
    assign presc_clr = (state_q == StIdle) | rise;

    btn_event_fsm_tick_gen #(
        .TICK_BITS (TICK_BITS)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

    // State, hold counter, edge register and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_q       <= 1'b0;
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            out_q      <= '0;
        end else begin
            db_q       <= db_i;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            out_q      <= out_d;
        end
    end

    // Next state and hold counter; a fall always takes priority over a tick.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d    = StPress;
                    hold_cnt_d = '0;
                end
            end
            StPress: begin
                if (fall) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (hold_cnt_q == LongLast) begin
                        state_d    = StLong;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
            end
            StLong: begin
                if (fall) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (RepeatOn && (hold_cnt_q == RepeatLast)) begin
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q != '1) begin
                        // Saturate so a disabled repeat never wraps back into a pulse.
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Output pulses derived from the current state and this cycle's edge/tick.
    always_comb begin
        out_d = '0;
        case (state_q)
            StIdle: begin
                out_d.press = rise;
            end
            StPress: begin
                if (fall) begin
                    out_d.rel         = 1'b1;
                    out_d.short_click = 1'b1;
                end else if (tick && (hold_cnt_q == LongLast)) begin
                    out_d.long_press = 1'b1;
                end
            end
            StLong: begin
                if (fall) begin
                    out_d.rel = 1'b1;
                end else if (tick && RepeatOn && (hold_cnt_q == RepeatLast)) begin
                    out_d.rpt = 1'b1;
                end
            end
            default: begin
                out_d = '0;
            end
        endcase
        // Held stays up through the release cycle, then drops.
        out_d.held = (state_d != StIdle) | out_d.rel;
    end

    assign press_o       = out_q.press;
    assign release_o     = out_q.rel;
    assign short_click_o = out_q.short_click;
    assign long_press_o  = out_q.long_press;
    assign repeat_o      = out_q.rpt;
    assign held_o        = out_q.held;

endmodule

// File: tb/tb_btn_event_fsm.sv
// Randomised bench for btn_event_fsm with a timing-based reference model.
module tb_btn_event_fsm;

    localparam int TB     = 2;
    localparam int Period = 1 << TB;
    localparam int LongT  = 3;
    localparam int LongClk = LongT * Period;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic db = 1'b0;

    logic p0, r0, s0, l0, q0, h0;
    logic p1, r1, s1, l1, q1, h1;
    logic [5:0] o [2];

    always #5 clk = ~clk;

    btn_event_fsm #(
        .TICK_BITS    (TB),
        .LONG_TICKS   (LongT),
        .REPEAT_TICKS (2),
        .CNT_W        (8)
    ) dut0 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .db_i          (db),
        .press_o       (p0),
        .release_o     (r0),
        .short_click_o (s0),
        .long_press_o  (l0),
        .repeat_o      (q0),
        .held_o        (h0)
    );

    btn_event_fsm #(
        .TICK_BITS    (TB),
        .LONG_TICKS   (LongT),
        .REPEAT_TICKS (0),
        .CNT_W        (8)
    ) dut1 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .db_i          (db),
        .press_o       (p1),
        .release_o     (r1),
        .short_click_o (s1),
        .long_press_o  (l1),
        .repeat_o      (q1),
        .held_o        (h1)
    );

    assign o[0] = {p0, r0, s0, l0, q0, h0};
    assign o[1] = {p1, r1, s1, l1, q1, h1};

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: events follow from clocks elapsed since the rising edge.
    int   rep [2] = '{2, 0};
    bit   in_hold [2];
    bit   long_done [2];
    bit   dprev [2];
    int   k [2];
    logic [5:0] exp_o [2];

    // Event counters observed on the outputs, for literal scenario checks.
    int n_press0, n_rel0, n_short0, n_long0, n_rep0, n_held0, n_long1, n_rep1;
    int c_press0, c_rel0, c_long0, c_rep0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            in_hold[i]   = 1'b0;
            long_done[i] = 1'b0;
            dprev[i]     = 1'b0;
            k[i]         = 0;
            exp_o[i]     = '0;
        end
    endtask

    // Bits: 5 press, 4 release, 3 short_click, 2 long_press, 1 repeat, 0 held.
    task automatic model_step(input int i, input bit d);
        bit rise, fall;
        logic [5:0] e;
        e = '0;
        rise = d && !dprev[i];
        fall = !d && dprev[i];
        dprev[i] = d;
        if (!in_hold[i]) begin
            if (rise) begin
                in_hold[i]   = 1'b1;
                k[i]         = 0;
                long_done[i] = 1'b0;
                e[5]         = 1'b1;
            end
        end else begin
            k[i]++;
            if (fall) begin
                e[4]       = 1'b1;
                e[3]       = !long_done[i];
                in_hold[i] = 1'b0;
            end else if (k[i] == LongClk) begin
                e[2]         = 1'b1;
                long_done[i] = 1'b1;
            end else if (long_done[i] && rep[i] != 0 &&
                         ((k[i] - LongClk) % (rep[i] * Period)) == 0) begin
                e[1] = 1'b1;
            end
        end
        e[0] = in_hold[i] || e[4];
        exp_o[i] = e;
    endtask

    task automatic clear_counts();
        n_press0 = 0; n_rel0 = 0; n_short0 = 0; n_long0 = 0; n_rep0 = 0; n_held0 = 0;
        n_long1 = 0; n_rep1 = 0;
        c_press0 = 0; c_rel0 = 0; c_long0 = 0; c_rep0 = 0;
    endtask

    // Compare process: step the model and check every output each cycle.
    string names [6] = '{"held", "repeat", "long_press", "short_click", "release", "press"};
    initial begin
        model_reset();
        clear_counts();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step(0, db);
                model_step(1, db);
            end
            for (int i = 0; i < 2; i++) begin
                for (int b = 0; b < 6; b++) begin
                    chk($sformatf("dut%0d.%s", i, names[b]), int'(o[i][b]), int'(exp_o[i][b]));
                end
            end
            if (p0) begin n_press0++; c_press0 = cyc; end
            if (r0) begin n_rel0++; c_rel0 = cyc; end
            if (s0) n_short0++;
            if (l0) begin n_long0++; c_long0 = cyc; end
            if (q0) begin n_rep0++; c_rep0 = cyc; end
            if (h0) n_held0++;
            if (l1) n_long1++;
            if (q1) n_rep1++;
        end
    end

    // Drive db at a falling edge and hold it for n cycles.
    task automatic drive(input bit v, input int n);
        db = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset.outputs0", int'(o[0]), 0);
        chk("reset.outputs1", int'(o[1]), 0);
        rst_n = 1'b1;
        drive(0, 4);

        // 1: short press of 5 clk.
        clear_counts();
        drive(1, 5);
        drive(0, 6);
        chk("s1.press_cnt", n_press0, 1);
        chk("s1.release_cnt", n_rel0, 1);
        chk("s1.short_cnt", n_short0, 1);
        chk("s1.long_cnt", n_long0, 0);
        chk("s1.press_to_release", c_rel0 - c_press0, 5);
        chk("s1.held_cycles", n_held0, 6);
        chk("s1.held_after", int'(h0), 0);

        // 2: 40 clk hold, long press then repeats.
        clear_counts();
        drive(1, 40);
        drive(0, 6);
        chk("s2.long_cnt", n_long0, 1);
        chk("s2.press_to_long", c_long0 - c_press0, 12);
        chk("s2.repeat_cnt", n_rep0, 3);
        chk("s2.press_to_last_repeat", c_rep0 - c_press0, 36);
        chk("s2.short_cnt", n_short0, 0);
        chk("s2.release_cnt", n_rel0, 1);
        chk("s2.norep_long_cnt", n_long1, 1);
        chk("s2.norep_repeat_cnt", n_rep1, 0);

        // 3: single-cycle glitch.
        clear_counts();
        drive(1, 1);
        drive(0, 4);
        chk("s3.press_cnt", n_press0, 1);
        chk("s3.short_cnt", n_short0, 1);
        chk("s3.press_to_release", c_rel0 - c_press0, 1);
        chk("s3.held_cycles", n_held0, 2);

        // 4: fall on the same edge as the long-press tick.
        clear_counts();
        drive(1, 12);
        drive(0, 6);
        chk("s4.short_cnt", n_short0, 1);
        chk("s4.long_cnt", n_long0, 0);
        chk("s4.press_to_release", c_rel0 - c_press0, 12);

        // 5: asynchronous reset while in LONG.
        clear_counts();
        drive(1, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("s5.async_outputs0", int'(o[0]), 0);
        chk("s5.async_outputs1", int'(o[1]), 0);
        @(negedge clk);
        @(negedge clk);
        chk("s5.no_release", n_rel0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s5.press_after_reset", int'(p0), 1);
        @(negedge clk);
        drive(0, 6);

        // 6: very long hold; disabled repeat must saturate without wrapping.
        clear_counts();
        drive(1, 1100);
        drive(0, 6);
        chk("s6.norep_long_cnt", n_long1, 1);
        chk("s6.norep_repeat_cnt", n_rep1, 0);
        chk("s6.long_cnt", n_long0, 1);
        chk("s6.repeat_cnt", n_rep0, 135);

        // Random segments with occasional asynchronous resets.
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                drive(1'($urandom_range(0, 1)), int'($urandom_range(30, 80)));
            end else begin
                drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 16)));
            end
        end
        drive(0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
